fc_rx_credit_manager: RTL and testbench



---
 rtl/fc_rx_credit_manager.sv | 192 +++++++++++++++++++
 tb/tb_fc_rx_credit_manager.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_rx_credit_manager.sv
// Receive-side flow-control credit manager for posted headers.
// Holds received TLP words in a small FIFO, returns one credit per pop,
// and drives InitFC/UpdateFC requests toward the link layer. Requests
// are sent once enough credits are released or after a quiet period.
module fc_rx_credit_manager #(
  parameter int DATA_WIDTH    = 8,
  parameter int BUF_DEPTH     = 16,
  parameter int UPDATE_THRESH = 4,
  parameter int UPDATE_PERIOD = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tlp_valid,
  input  logic [DATA_WIDTH-1:0] tlp_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] credits_allocated,
  output logic [DATA_WIDTH-1:0] credits_received,
  output logic                  updatefc_valid,
  output logic [DATA_WIDTH-1:0] updatefc_credit,
  input  logic                  updatefc_ready,
  output logic                  overflow_err
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int TMR_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;

  localparam logic [PTR_W-1:0]      PTR_LAST  = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(BUF_DEPTH);
  localparam logic [DATA_WIDTH-1:0] CRED_INIT = DATA_WIDTH'(BUF_DEPTH);
  localparam logic [DATA_WIDTH-1:0] THRESH_V  = DATA_WIDTH'(UPDATE_THRESH);
  localparam logic [TMR_W-1:0]      TMR_LAST  = TMR_W'(UPDATE_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_SEND = 2'd2
  } fc_state_e;

  // Storage and buffer bookkeeping
  logic [DATA_WIDTH-1:0] mem_r [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  rd_valid_r;
  logic [DATA_WIDTH-1:0] cred_alloc_r;
  logic [DATA_WIDTH-1:0] cred_recv_r;
  logic                  overflow_r;

  // Advertisement state
  fc_state_e             state_r;
  logic                  upd_valid_r;
  logic [DATA_WIDTH-1:0] upd_credit_r;
  logic [DATA_WIDTH-1:0] last_adv_r;
  logic [TMR_W-1:0]      timer_r;

  // Combinational helpers
  logic                  full_s;
  logic                  empty_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic                  drop_s;
  logic [PTR_W-1:0]      wr_ptr_nxt_s;
  logic [PTR_W-1:0]      rd_ptr_nxt_s;
  logic [DATA_WIDTH-1:0] adv_gap_s;
  logic                  send_due_s;

  // Accept/drop decisions use the occupancy at cycle start, so a pop in the
  // same cycle never makes room for a write into a full buffer.
  always_comb begin
    full_s       = (count_r == CNT_FULL);
    empty_s      = (count_r == {CNT_W{1'b0}});
    wr_acc_s     = tlp_valid & ~full_s;
    drop_s       = tlp_valid & full_s;
    rd_acc_s     = rd_en & ~empty_s;
    adv_gap_s    = cred_alloc_r - last_adv_r;
    send_due_s   = (adv_gap_s >= THRESH_V) || (timer_r == TMR_LAST);
    if (wr_ptr_r == PTR_LAST) begin
      wr_ptr_nxt_s = {PTR_W{1'b0}};
    end else begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
    end
    if (rd_ptr_r == PTR_LAST) begin
      rd_ptr_nxt_s = {PTR_W{1'b0}};
    end else begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
    end
  end

  // Payload storage; contents are don't-care once pointers are reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc_s) begin
      mem_r[wr_ptr_r] <= tlp_data;
    end
  end

  // Pointers, occupancy, credit counters, read port and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      cred_recv_r  <= {DATA_WIDTH{1'b0}};
      cred_alloc_r <= CRED_INIT;
      overflow_r   <= 1'b0;
      rd_valid_r   <= 1'b0;
      rd_data_r    <= {DATA_WIDTH{1'b0}};
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r    <= wr_ptr_nxt_s;
        cred_recv_r <= cred_recv_r + DATA_WIDTH'(1);
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (rd_acc_s) begin
        rd_data_r    <= mem_r[rd_ptr_r];
        rd_ptr_r     <= rd_ptr_nxt_s;
        cred_alloc_r <= cred_alloc_r + DATA_WIDTH'(1);
        rd_valid_r   <= 1'b1;
      end else begin
        rd_valid_r   <= 1'b0;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // InitFC/UpdateFC sequencer. The advertised credit is captured when a
  // request is raised and held until the link layer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_INIT;
      upd_valid_r  <= 1'b1;
      upd_credit_r <= CRED_INIT;
      last_adv_r   <= {DATA_WIDTH{1'b0}};
      timer_r      <= {TMR_W{1'b0}};
    end else begin
      case (state_r)
        ST_INIT: begin
          if (updatefc_ready) begin
            state_r     <= ST_IDLE;
            upd_valid_r <= 1'b0;
            last_adv_r  <= upd_credit_r;
            timer_r     <= {TMR_W{1'b0}};
          end
        end
        ST_IDLE: begin
          if (send_due_s) begin
            state_r      <= ST_SEND;
            upd_valid_r  <= 1'b1;
            upd_credit_r <= cred_alloc_r;
            timer_r      <= {TMR_W{1'b0}};
          end else begin
            timer_r      <= timer_r + TMR_W'(1);
          end
        end
        ST_SEND: begin
          if (updatefc_ready) begin
            state_r     <= ST_IDLE;
            upd_valid_r <= 1'b0;
            last_adv_r  <= upd_credit_r;
            timer_r     <= {TMR_W{1'b0}};
          end
        end
        default: begin
          state_r      <= ST_INIT;
          upd_valid_r  <= 1'b1;
          upd_credit_r <= cred_alloc_r;
          timer_r      <= {TMR_W{1'b0}};
        end
      endcase
    end
  end

  // The reset edge already loads the InitFC request so it shows in the first
  // cycle after release; masking with rst keeps it silent while reset is held.
  assign updatefc_valid    = upd_valid_r & ~rst;
  assign updatefc_credit   = upd_credit_r;
  assign rd_data           = rd_data_r;
  assign rd_valid          = rd_valid_r;
  assign credits_allocated = cred_alloc_r;
  assign credits_received  = cred_recv_r;
  assign overflow_err      = overflow_r;

endmodule

// File: tb/tb_fc_rx_credit_manager.sv
// Self-checking bench for fc_rx_credit_manager: a reference FIFO model feeds
// a scoreboard of expected read data; scenario tasks check counters and the
// UpdateFC handshake.
module tb_fc_rx_credit_manager;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst;
  logic       tlp_valid;
  logic [7:0] tlp_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] credits_allocated;
  logic [7:0] credits_received;
  logic       updatefc_valid;
  logic [7:0] updatefc_credit;
  logic       updatefc_ready;
  logic       overflow_err;

  int         vectors;
  int         miscompares;

  // reference model state
  int         m_cnt;
  logic       m_ovf;
  logic       exp_rv;
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];

  fc_rx_credit_manager #(
    .DATA_WIDTH(8), .BUF_DEPTH(16), .UPDATE_THRESH(4), .UPDATE_PERIOD(64)
  ) dut (
    .clk(clk), .rst(rst), .tlp_valid(tlp_valid), .tlp_data(tlp_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .credits_allocated(credits_allocated), .credits_received(credits_received),
    .updatefc_valid(updatefc_valid), .updatefc_credit(updatefc_credit),
    .updatefc_ready(updatefc_ready), .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock: update the model, then compare read port, credit invariant
  // and sticky overflow against it.
  task automatic tick();
    logic       wa, ra, ov;
    logic [7:0] d, e, inv_act, inv_exp;
    wa = tlp_valid && (m_cnt < DEPTH);
    ra = rd_en && (m_cnt > 0);
    ov = tlp_valid && (m_cnt == DEPTH);
    d  = tlp_data;
    @(posedge clk);
    if (rst) begin
      m_cnt = 0; m_ovf = 1'b0; exp_rv = 1'b0;
      mq.delete(); exp_q.delete();
    end else begin
      if (ra) exp_q.push_back(mq.pop_front());
      if (wa) mq.push_back(d);
      m_cnt = m_cnt + (wa ? 1 : 0) - (ra ? 1 : 0);
      if (ov) m_ovf = 1'b1;
      exp_rv = ra;
    end
    #1;
    vectors++;
    if (rd_valid !== exp_rv) begin
      miscompares++;
      $display("FAIL rd_valid: got %0b expected %0b", rd_valid, exp_rv);
    end
    if (rd_valid === 1'b1 && exp_rv === 1'b1) begin
      e = exp_q.pop_front();
      vectors++;
      if (rd_data !== e) begin
        miscompares++;
        $display("FAIL rd_data: got %02h expected %02h", rd_data, e);
      end
    end
    inv_act = credits_allocated - credits_received;
    inv_exp = 8'(DEPTH - m_cnt);
    vectors++;
    if (inv_act !== inv_exp) begin
      miscompares++;
      $display("FAIL credit_invariant: got %0d expected %0d", inv_act, inv_exp);
    end
    vectors++;
    if (overflow_err !== m_ovf) begin
      miscompares++;
      $display("FAIL overflow_err: got %0b expected %0b", overflow_err, m_ovf);
    end
  endtask

  task automatic do_reset_init();
    tlp_valid = 1'b0; rd_en = 1'b0;
    rst = 1'b1; updatefc_ready = 1'b0;
    tick();
    rst = 1'b0; updatefc_ready = 1'b1;
    tick();
    updatefc_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tlp_valid = 1'b0; rd_en = 1'b0; updatefc_ready = 1'b0;
    tick();
    tick();
    vectors++;
    if (updatefc_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %0b expected 0", updatefc_valid);
    end
    vectors++;
    if (credits_allocated !== 8'd16 || credits_received !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_counters: got %0d/%0d expected 16/0", credits_allocated, credits_received);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (updatefc_valid !== 1'b1 || updatefc_credit !== 8'd16) begin
      miscompares++;
      $display("FAIL initfc: got valid %0b credit %0d expected 1/16", updatefc_valid, updatefc_credit);
    end
    updatefc_ready = 1'b1;
    tick();
    updatefc_ready = 1'b0;
    vectors++;
    if (updatefc_valid !== 1'b0 || credits_received !== 8'd0) begin
      miscompares++;
      $display("FAIL initfc_accept: got valid %0b recv %0d expected 0/0", updatefc_valid, credits_received);
    end
  endtask

  task automatic test_overflow();
    do_reset_init();
    for (int i = 0; i < DEPTH; i++) begin
      tlp_valid = 1'b1; tlp_data = 8'($urandom_range(0, 255));
      tick();
    end
    tlp_data = 8'hEE;
    tick();
    tlp_valid = 1'b0;
    vectors++;
    if (credits_received !== 8'd16 || overflow_err !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow: got recv %0d err %0b expected 16/1", credits_received, overflow_err);
    end
    for (int i = 0; i < 3; i++) tick();
    // drain everything plus one pop on an empty buffer
    rd_en = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();
    rd_en = 1'b0;
    tick();
    vectors++;
    if (credits_allocated !== 8'd32 || overflow_err !== 1'b1) begin
      miscompares++;
      $display("FAIL drain: got alloc %0d err %0b expected 32/1", credits_allocated, overflow_err);
    end
  endtask

  task automatic test_send_hold();
    int k;
    do_reset_init();
    for (int i = 0; i < DEPTH; i++) begin
      tlp_valid = 1'b1; tlp_data = 8'(i + 8'h40);
      tick();
    end
    tlp_valid = 1'b0; rd_en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (credits_allocated !== 8'd20 || updatefc_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL pop4: got alloc %0d valid %0b expected 20/0", credits_allocated, updatefc_valid);
    end
    tick();   // fifth pop; the UpdateFC is raised at this edge
    rd_en = 1'b0;
    vectors++;
    if (updatefc_valid !== 1'b1 || updatefc_credit !== 8'd20 || credits_allocated !== 8'd21) begin
      miscompares++;
      $display("FAIL send_entry: got valid %0b credit %0d alloc %0d expected 1/20/21",
               updatefc_valid, updatefc_credit, credits_allocated);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (updatefc_valid !== 1'b1 || updatefc_credit !== 8'd20) begin
        miscompares++;
        $display("FAIL send_hold: got valid %0b credit %0d expected 1/20", updatefc_valid, updatefc_credit);
      end
    end
    updatefc_ready = 1'b1;
    tick();
    updatefc_ready = 1'b0;
    vectors++;
    if (updatefc_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL send_accept: got valid %0b expected 0", updatefc_valid);
    end
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (updatefc_valid === 1'b1) begin k = i; break; end
    end
    vectors++;
    if (k != 64 || updatefc_credit !== 8'd21) begin
      miscompares++;
      $display("FAIL resend21: got after %0d cycles credit %0d expected 64/21", k, updatefc_credit);
    end
    updatefc_ready = 1'b1;
    tick();
    updatefc_ready = 1'b0;
  endtask

  task automatic test_timer();
    int k;
    do_reset_init();
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (updatefc_valid === 1'b1) begin k = i; break; end
    end
    vectors++;
    if (k != 64 || updatefc_credit !== 8'd16) begin
      miscompares++;
      $display("FAIL idle_resend: got after %0d cycles credit %0d expected 64/16", k, updatefc_credit);
    end
    updatefc_ready = 1'b1;
    tick();
    updatefc_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset_init();
    updatefc_ready = 1'b1;
    tlp_valid = 1'b1; tlp_data = 8'h00;
    tick();
    rd_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tlp_data = 8'($urandom_range(0, 255));
      tick();
    end
    tlp_valid = 1'b0;
    tick();
    rd_en = 1'b0;
    tick();
    updatefc_ready = 1'b0;
    vectors++;
    if (credits_received !== 8'd45 || credits_allocated !== 8'd61) begin
      miscompares++;
      $display("FAIL stream_wrap: got recv %0d alloc %0d expected 45/61", credits_received, credits_allocated);
    end
  endtask

  task automatic test_reset_in_send();
    do_reset_init();
    tlp_valid = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      tlp_data = 8'(8'hA0 + i);
      tick();
    end
    tlp_valid = 1'b0; rd_en = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    rd_en = 1'b0;
    vectors++;
    if (updatefc_valid !== 1'b1 || credits_allocated !== 8'd28 || credits_received !== 8'd16) begin
      miscompares++;
      $display("FAIL pre_reset: got valid %0b alloc %0d recv %0d expected 1/28/16",
               updatefc_valid, credits_allocated, credits_received);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if (updatefc_valid !== 1'b0 || credits_allocated !== 8'd16 ||
        credits_received !== 8'd0 || overflow_err !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got valid %0b alloc %0d recv %0d err %0b expected 0/16/0/0",
               updatefc_valid, credits_allocated, credits_received, overflow_err);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (updatefc_valid !== 1'b1 || updatefc_credit !== 8'd16) begin
      miscompares++;
      $display("FAIL re_initfc: got valid %0b credit %0d expected 1/16", updatefc_valid, updatefc_credit);
    end
    updatefc_ready = 1'b1;
    tick();
    updatefc_ready = 1'b0;
    vectors++;
    if (updatefc_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL re_initfc_accept: got valid %0b expected 0", updatefc_valid);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    m_cnt = 0; m_ovf = 1'b0; exp_rv = 1'b0;
    rst = 1'b1; tlp_valid = 1'b0; tlp_data = 8'h00; rd_en = 1'b0; updatefc_ready = 1'b0;
    test_reset();
    test_overflow();
    test_send_hold();
    test_timer();
    test_back_to_back();
    test_reset_in_send();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
